// File: rtl/mc_ctrl_if.sv
// Memory handshake bundle between the control unit and the unified I/D memory.
interface mc_ctrl_if;
   logic       mem_req;
   logic       mem_ready;
   logic       IorD;
   logic [1:0] MemWrite;

   modport master (output mem_req, output IorD, output MemWrite, input mem_ready);
   modport slave  (input mem_req, input IorD, input MemWrite, output mem_ready);
endinterface

// File: rtl/mc_ctrl.sv
// Multicycle MIPS control unit: sequences fetch/decode/exec/mem/writeback,
// drives the memory handshake and counts retired instructions.
module mc_ctrl #(
   parameter int unsigned ALUOP_W = 4,
   parameter int unsigned CNT_W   = 32
) (
   input  logic               clk,
   input  logic               rstn,
   mc_ctrl_if.master          mem,
   input  logic [5:0]         Op,
   input  logic [5:0]         Funct,
   input  logic               Zero,
   output logic               IRWrite,
   output logic               PCWrite,
   output logic [1:0]         NPCOp,
   output logic               RegWrite,
   output logic               EXTOp,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic [1:0]         GPRSel,
   output logic [1:0]         WDSel,
   output logic [2:0]         LAddr,
   output logic [3:0]         state,
   output logic               illegal,
   output logic [CNT_W-1:0]   instret
);

   localparam int unsigned AW = 4;
   localparam logic [AW-1:0] ALU_ADD = 4'b0001, ALU_SUB = 4'b0010, ALU_AND = 4'b0011,
                             ALU_OR = 4'b0100, ALU_SLT = 4'b0101, ALU_SLTU = 4'b0110,
                             ALU_NOR = 4'b1000, ALU_XOR = 4'b1001, ALU_SRLV = 4'b1010,
                             ALU_SLLV = 4'b1011, ALU_SRAV = 4'b1100;

   typedef enum logic [3:0] {
      S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXEC = 4'd3, S_MEMRD = 4'd4,
      S_MEMWR = 4'd5, S_WB = 4'd6, S_BRANCH = 4'd7, S_JUMP = 4'd8, S_TRAP = 4'd9
   } state_e;

   typedef enum logic [2:0] {
      CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP, CLS_ILL
   } cls_e;

   state_e         r_state, w_next;
   cls_e           r_cls, w_cls;
   logic [2:0]     r_sub, w_sub;
   logic [AW-1:0]  r_aluop, w_aluop, w_aluop_out;
   logic           r_extop, w_extop, r_itype, w_itype, r_bne, w_bne, r_jal, w_jal;
   logic [1:0]     r_gprsel, w_gprsel;
   logic           r_illegal;
   logic [CNT_W-1:0] r_instret;
   logic           w_retire, w_mem_req, w_iord;
   logic [1:0]     w_memwrite;

   // Instruction decode from the IR fields; only sampled in DECODE.
   always_comb begin
      w_cls    = CLS_ILL;
      w_sub    = 3'b000;
      w_aluop  = ALU_ADD;
      w_extop  = 1'b1;
      w_gprsel = 2'b01;
      w_itype  = 1'b1;
      w_bne    = 1'b0;
      w_jal    = 1'b0;
      case (Op)
         6'b000000: begin
            w_cls    = CLS_ALU;
            w_itype  = 1'b0;
            w_gprsel = 2'b00;
            case (Funct)
               6'b100000, 6'b100001: w_aluop = ALU_ADD;
               6'b100010, 6'b100011: w_aluop = ALU_SUB;
               6'b100100:            w_aluop = ALU_AND;
               6'b100101:            w_aluop = ALU_OR;
               6'b100111:            w_aluop = ALU_NOR;
               6'b100110:            w_aluop = ALU_XOR;
               6'b101010:            w_aluop = ALU_SLT;
               6'b101011:            w_aluop = ALU_SLTU;
               6'b000100:            w_aluop = ALU_SLLV;
               6'b000110:            w_aluop = ALU_SRLV;
               6'b000111:            w_aluop = ALU_SRAV;
               default:              w_cls   = CLS_ILL;
            endcase
         end
         6'b001000: w_cls = CLS_ALU;
         6'b001101: begin w_cls = CLS_ALU; w_aluop = ALU_OR; w_extop = 1'b0; end
         6'b100011: begin w_cls = CLS_LOAD;  w_sub = 3'b000; end
         6'b100000: begin w_cls = CLS_LOAD;  w_sub = 3'b001; end
         6'b100100: begin w_cls = CLS_LOAD;  w_sub = 3'b010; end
         6'b100001: begin w_cls = CLS_LOAD;  w_sub = 3'b011; end
         6'b100101: begin w_cls = CLS_LOAD;  w_sub = 3'b100; end
         6'b101011: begin w_cls = CLS_STORE; w_sub = 3'b001; end
         6'b101000: begin w_cls = CLS_STORE; w_sub = 3'b010; end
         6'b101001: begin w_cls = CLS_STORE; w_sub = 3'b011; end
         6'b000100: w_cls = CLS_BRANCH;
         6'b000101: begin w_cls = CLS_BRANCH; w_bne = 1'b1; end
         6'b000010: w_cls = CLS_JUMP;
         6'b000011: begin w_cls = CLS_JUMP; w_jal = 1'b1; w_gprsel = 2'b10; end
         default:   w_cls = CLS_ILL;
      endcase
   end

   // State register, decoded-instruction latch, sticky illegal flag, retire counter.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= S_IDLE;
         r_cls     <= CLS_ALU;
         r_sub     <= 3'b000;
         r_aluop   <= '0;
         r_extop   <= 1'b0;
         r_itype   <= 1'b0;
         r_bne     <= 1'b0;
         r_jal     <= 1'b0;
         r_gprsel  <= 2'b00;
         r_illegal <= 1'b0;
         r_instret <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_DECODE) begin
            r_cls    <= w_cls;
            r_sub    <= w_sub;
            r_aluop  <= w_aluop;
            r_extop  <= w_extop;
            r_itype  <= w_itype;
            r_bne    <= w_bne;
            r_jal    <= w_jal;
            r_gprsel <= w_gprsel;
            if (w_cls == CLS_ILL) r_illegal <= 1'b1;
         end
         if (w_retire) r_instret <= r_instret + CNT_W'(1);
      end
   end

   // Next-state and control outputs.
   always_comb begin
      w_next      = r_state;
      w_retire    = 1'b0;
      w_mem_req   = 1'b0;
      w_iord      = 1'b0;
      w_memwrite  = 2'b00;
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      NPCOp       = 2'b00;
      RegWrite    = 1'b0;
      EXTOp       = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      w_aluop_out = '0;
      GPRSel      = 2'b00;
      WDSel       = 2'b00;
      LAddr       = 3'b000;
      case (r_state)
         S_IDLE: w_next = S_FETCH;
         S_FETCH: begin
            w_mem_req = 1'b1;
            if (mem.mem_ready) begin
               IRWrite = 1'b1;
               PCWrite = 1'b1;
               w_next  = S_DECODE;
            end
         end
         S_DECODE: begin
            case (w_cls)
               CLS_BRANCH: w_next = S_BRANCH;
               CLS_JUMP:   w_next = S_JUMP;
               CLS_ILL:    w_next = S_TRAP;
               default:    w_next = S_EXEC;
            endcase
         end
         S_EXEC: begin
            ALUSrcA     = 1'b1;
            ALUSrcB     = r_itype ? 2'b10 : 2'b00;
            w_aluop_out = r_aluop;
            EXTOp       = r_extop;
            case (r_cls)
               CLS_LOAD:  w_next = S_MEMRD;
               CLS_STORE: w_next = S_MEMWR;
               default:   w_next = S_WB;
            endcase
         end
         S_MEMRD: begin
            w_mem_req = 1'b1;
            w_iord    = 1'b1;
            LAddr     = r_sub;
            if (mem.mem_ready) w_next = S_WB;
         end
         S_MEMWR: begin
            w_mem_req  = 1'b1;
            w_iord     = 1'b1;
            w_memwrite = r_sub[1:0];
            if (mem.mem_ready) begin
               w_retire = 1'b1;
               w_next   = S_FETCH;
            end
         end
         S_WB: begin
            RegWrite = 1'b1;
            if (r_cls == CLS_LOAD) begin
               GPRSel = 2'b01;
               WDSel  = 2'b01;
               LAddr  = r_sub;
            end else begin
               GPRSel = r_gprsel;
            end
            w_retire = 1'b1;
            w_next   = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            w_aluop_out = ALU_SUB;
            NPCOp       = 2'b01;
            PCWrite     = r_bne ? ~Zero : Zero;
            w_retire    = 1'b1;
            w_next      = S_FETCH;
         end
         S_JUMP: begin
            NPCOp   = 2'b10;
            PCWrite = 1'b1;
            if (r_jal) begin
               RegWrite = 1'b1;
               GPRSel   = 2'b10;
               WDSel    = 2'b10;
            end
            w_retire = 1'b1;
            w_next   = S_FETCH;
         end
         S_TRAP:  w_next = S_TRAP;
         default: w_next = S_IDLE;
      endcase
   end

   assign mem.mem_req  = w_mem_req;
   assign mem.IorD     = w_iord;
   assign mem.MemWrite = w_memwrite;
   assign ALUOp        = ALUOP_W'(w_aluop_out);
   assign state        = r_state;
   assign illegal      = r_illegal;
   assign instret      = r_instret;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for the multicycle control unit.
module tb_mc_ctrl;
   logic        clk = 1'b0;
   logic        rstn;
   logic [5:0]  Op, Funct;
   logic        Zero;
   logic        IRWrite, PCWrite, RegWrite, EXTOp, ALUSrcA, illegal;
   logic [1:0]  NPCOp, ALUSrcB, GPRSel, WDSel;
   logic [3:0]  ALUOp, state;
   logic [2:0]  LAddr;
   logic [31:0] instret;
   int          n_chk = 0;
   int          n_fail = 0;

   mc_ctrl_if u_if ();

   mc_ctrl #(.ALUOP_W(4), .CNT_W(32)) dut (
      .clk(clk), .rstn(rstn), .mem(u_if.master), .Op(Op), .Funct(Funct), .Zero(Zero),
      .IRWrite(IRWrite), .PCWrite(PCWrite), .NPCOp(NPCOp), .RegWrite(RegWrite),
      .EXTOp(EXTOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .GPRSel(GPRSel), .WDSel(WDSel), .LAddr(LAddr), .state(state),
      .illegal(illegal), .instret(instret)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present an instruction in FETCH with ready high, then advance into DECODE.
   task automatic fetch(input logic [5:0] op, input logic [5:0] fn);
      Op = op; Funct = fn; u_if.mem_ready = 1'b1;
      #1;
      check_eq("fetch_state", 32'(state), 32'd1);
      check_eq("fetch_irw", 32'(IRWrite), 32'd1);
      tick();
      check_eq("decode_state", 32'(state), 32'd2);
   endtask

   initial begin
      rstn = 1'b0; Op = '0; Funct = '0; Zero = 1'b0; u_if.mem_ready = 1'b0;
      tick(); tick();
      check_eq("rst_state", 32'(state), 32'd0);
      check_eq("rst_req", 32'(u_if.mem_req), 32'd0);
      check_eq("rst_ill", 32'(illegal), 32'd0);
      check_eq("rst_cnt", instret, 32'd0);
      rstn = 1'b1;
      tick();
      check_eq("fetch_entry", 32'(state), 32'd1);
      check_eq("fetch_req", 32'(u_if.mem_req), 32'd1);
      check_eq("fetch_iord", 32'(u_if.IorD), 32'd0);
      check_eq("fetch_wait_irw", 32'(IRWrite), 32'd0);

      // addu
      fetch(6'b000000, 6'b100001);
      check_eq("addu_dec_rw", 32'(RegWrite), 32'd0);
      tick();
      Op = 6'b111111;   // IR contents no longer matter after DECODE
      #1;
      check_eq("addu_exec_state", 32'(state), 32'd3);
      check_eq("addu_exec_aluop", 32'(ALUOp), 32'd1);
      check_eq("addu_exec_srcb", 32'(ALUSrcB), 32'd0);
      check_eq("addu_exec_srca", 32'(ALUSrcA), 32'd1);
      check_eq("addu_exec_rw", 32'(RegWrite), 32'd0);
      tick();
      check_eq("addu_wb_state", 32'(state), 32'd6);
      check_eq("addu_wb_rw", 32'(RegWrite), 32'd1);
      check_eq("addu_wb_gpr", 32'(GPRSel), 32'd0);
      check_eq("addu_wb_wd", 32'(WDSel), 32'd0);
      tick();
      check_eq("addu_back_fetch", 32'(state), 32'd1);
      check_eq("addu_retired", instret, 32'd1);
      check_eq("addu_rw_off", 32'(RegWrite), 32'd0);

      // lhu, two wait cycles on data read
      fetch(6'b100101, 6'b000000);
      tick();
      check_eq("lhu_exec_srcb", 32'(ALUSrcB), 32'd2);
      check_eq("lhu_exec_ext", 32'(EXTOp), 32'd1);
      check_eq("lhu_exec_aluop", 32'(ALUOp), 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         u_if.mem_ready = (i == 2);
         #1;
         check_eq("lhu_memrd_state", 32'(state), 32'd4);
         check_eq("lhu_memrd_req", 32'(u_if.mem_req), 32'd1);
         check_eq("lhu_memrd_iord", 32'(u_if.IorD), 32'd1);
         check_eq("lhu_memrd_laddr", 32'(LAddr), 32'd4);
      end
      tick();
      check_eq("lhu_wb_state", 32'(state), 32'd6);
      check_eq("lhu_wb_gpr", 32'(GPRSel), 32'd1);
      check_eq("lhu_wb_wd", 32'(WDSel), 32'd1);
      check_eq("lhu_wb_laddr", 32'(LAddr), 32'd4);
      check_eq("lhu_wb_req", 32'(u_if.mem_req), 32'd0);
      tick();
      check_eq("lhu_retired", instret, 32'd2);

      // sb, three wait cycles on write
      fetch(6'b101000, 6'b000000);
      tick();
      check_eq("sb_exec_rw", 32'(RegWrite), 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         u_if.mem_ready = (i == 3);
         #1;
         check_eq("sb_memwr_state", 32'(state), 32'd5);
         check_eq("sb_memwr_mw", 32'(u_if.MemWrite), 32'd2);
         check_eq("sb_memwr_rw", 32'(RegWrite), 32'd0);
      end
      tick();
      check_eq("sb_back_fetch", 32'(state), 32'd1);
      check_eq("sb_mw_off", 32'(u_if.MemWrite), 32'd0);
      check_eq("sb_retired", instret, 32'd3);

      // beq taken, and PCWrite following Zero
      fetch(6'b000100, 6'b000000);
      tick();
      Zero = 1'b1; #1;
      check_eq("beq_state", 32'(state), 32'd7);
      check_eq("beq_pcw", 32'(PCWrite), 32'd1);
      check_eq("beq_npc", 32'(NPCOp), 32'd1);
      check_eq("beq_aluop", 32'(ALUOp), 32'd2);
      Zero = 1'b0; #1;
      check_eq("beq_nz_pcw", 32'(PCWrite), 32'd0);
      tick();
      check_eq("beq_retired", instret, 32'd4);

      // bne with Zero=1: not taken
      fetch(6'b000101, 6'b000000);
      tick();
      Zero = 1'b1; #1;
      check_eq("bne_pcw", 32'(PCWrite), 32'd0);
      check_eq("bne_npc", 32'(NPCOp), 32'd1);
      tick();
      Zero = 1'b0;
      check_eq("bne_retired", instret, 32'd5);

      // jal
      fetch(6'b000011, 6'b000000);
      tick();
      check_eq("jal_state", 32'(state), 32'd8);
      check_eq("jal_pcw", 32'(PCWrite), 32'd1);
      check_eq("jal_npc", 32'(NPCOp), 32'd2);
      check_eq("jal_rw", 32'(RegWrite), 32'd1);
      check_eq("jal_gpr", 32'(GPRSel), 32'd2);
      check_eq("jal_wd", 32'(WDSel), 32'd2);
      tick();
      check_eq("jal_retired", instret, 32'd6);

      // j: no link write
      fetch(6'b000010, 6'b000000);
      tick();
      check_eq("j_rw", 32'(RegWrite), 32'd0);
      check_eq("j_pcw", 32'(PCWrite), 32'd1);
      tick();
      check_eq("j_retired", instret, 32'd7);

      // ori: zero-extended immediate, I-type writeback to rt
      fetch(6'b001101, 6'b000000);
      tick();
      check_eq("ori_aluop", 32'(ALUOp), 32'd4);
      check_eq("ori_ext", 32'(EXTOp), 32'd0);
      check_eq("ori_srcb", 32'(ALUSrcB), 32'd2);
      tick();
      check_eq("ori_wb_gpr", 32'(GPRSel), 32'd1);
      tick();
      check_eq("ori_retired", instret, 32'd8);

      // illegal opcode traps and freezes the counter
      fetch(6'b111111, 6'b000000);
      tick();
      for (int i = 0; i < 3; i++) begin
         check_eq("trap_state", 32'(state), 32'd9);
         check_eq("trap_ill", 32'(illegal), 32'd1);
         check_eq("trap_req", 32'(u_if.mem_req), 32'd0);
         check_eq("trap_rw", 32'(RegWrite), 32'd0);
         check_eq("trap_cnt", instret, 32'd8);
         tick();
      end
      rstn = 1'b0; #1;
      check_eq("trap_rst_state", 32'(state), 32'd0);
      check_eq("trap_rst_ill", 32'(illegal), 32'd0);
      check_eq("trap_rst_cnt", instret, 32'd0);
      rstn = 1'b1;

      // reset mid-fetch wait drops the request at once
      tick();
      u_if.mem_ready = 1'b0; #1;
      check_eq("midrst_req_before", 32'(u_if.mem_req), 32'd1);
      rstn = 1'b0; #1;
      check_eq("midrst_req", 32'(u_if.mem_req), 32'd0);
      check_eq("midrst_state", 32'(state), 32'd0);
      check_eq("midrst_cnt", instret, 32'd0);
      tick();
      rstn = 1'b1;
      tick();

      // R-type with unknown funct is illegal
      fetch(6'b000000, 6'b111111);
      tick();
      check_eq("badfn_state", 32'(state), 32'd9);
      check_eq("badfn_ill", 32'(illegal), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multicycle MIPS control unit. It replaces the single-cycle combinational decoder with a registered state machine that sequences fetch, decode, execute, memory and writeback. Unified instruction/data memory access is driven over a req/ready handshake with wait states. The block sits between the instruction register (Op/Funct) and the datapath muxes, ALU, register file, PC and memory. It also keeps a retired-instruction counter.

## Interface
Parameters:
- ALUOP_W, 4, ALUOp width (≥4; bits above [3] driven 0)
- CNT_W, 32, retired-instruction counter width

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- Op  in  6  opcode from IR; valid from DECODE onward
- Funct  in  6  funct from IR
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request (fetch, load or store)
- IorD  out  1  memory address source: 0 = PC, 1 = ALUOut
- IRWrite  out  1  load IR
- PCWrite  out  1  update PC with the NPC result
- NPCOp  out  2  00 = PC+4, 01 = branch, 10 = jump
- RegWrite  out  1  register-file write strobe
- MemWrite  out  2  00 none, 01 sw, 10 sb, 11 sh
- EXTOp  out  1  1 = sign-extend imm
- ALUSrcA  out  1  0 = PC, 1 = rs
- ALUSrcB  out  2  00 = rt, 01 = 4, 10 = ext imm
- ALUOp  out  ALUOP_W  ALU operation code
- GPRSel  out  2  00 = rd, 01 = rt, 10 = $31
- WDSel  out  2  00 = ALU, 01 = MEM, 10 = PC
- LAddr  out  3  load type: 000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu
- state  out  4  current state, for debug
- illegal  out  1  sticky undecodable-instruction flag
- instret  out  CNT_W  retired-instruction count

## Operation
- Supported instructions:
  - R-type: add, addu, sub, subu, and, or, nor, xor, slt, sltu, sllv, srlv, srav
  - I-type: addi, ori, lw, lb, lbu, lh, lhu, sw, sb, sh, beq (000100), bne (000101)
  - J-type: j, jal
  - Any other Op, or an R-type with any other Funct, is illegal.
- ALUOp encoding: ADD 0001, SUB 0010, AND 0011, OR 0100, SLT 0101, SLTU 0110, NOR 1000, XOR 1001, SRLV 1010, SLLV 1011, SRAV 1100.
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEMRD=4, MEMWR=5, WB=6, BRANCH=7, JUMP=8, TRAP=9.
- IDLE: all outputs 0; next state FETCH unconditionally.
- FETCH: mem_req=1, IorD=0.
  - Hold while mem_ready=0.
  - On mem_ready: IRWrite=1, PCWrite=1, NPCOp=00, then go to DECODE.
- DECODE:
  - Register a decoded class (alu, load, store, branch, jump), load/store subtype, ALUOp, EXTOp, GPRSel.
  - All later states use only these registered values; Op/Funct may change after DECODE.
  - Next state: alu/load/store → EXEC; beq/bne → BRANCH; j/jal → JUMP; illegal → TRAP.
- EXEC:
  - ALUSrcA=1.
  - ALUSrcB=10 for I-type, 00 for R-type.
  - ALUOp: ADD for load/store/addi, OR for ori, decoded value for R-type.
  - EXTOp=1 except ori.
  - Next state: loads → MEMRD; stores → MEMWR; others → WB.
- MEMRD: mem_req=1, IorD=1, LAddr=subtype; hold until mem_ready, then WB.
- MEMWR:
  - mem_req=1, IorD=1.
  - MemWrite=subtype code, held constant for every cycle of the request.
  - On mem_ready: retire, go to FETCH.
- WB:
  - RegWrite=1 for exactly one cycle.
  - ALU ops: GPRSel=00 for R-type, 01 for I-type, WDSel=00.
  - Loads: GPRSel=01, WDSel=01, LAddr held.
  - Retire, go to FETCH.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, NPCOp=01.
  - PCWrite=(beq&Zero)|(bne&~Zero).
  - Retire, go to FETCH.
- JUMP:
  - NPCOp=10, PCWrite=1.
  - jal additionally: RegWrite=1, GPRSel=10, WDSel=10.
  - Retire, go to FETCH.
- TRAP: illegal=1, all strobes 0; stay until reset.
- Retire: instret+1, wrapping modulo 2^CNT_W.
- Any output not listed for a state is 0.

## Timing
- Reset (asynchronous, rstn=0):
  - state=IDLE, illegal=0, instret=0, decoded registers 0.
  - All outputs 0, including mem_req.
- Outputs are Moore (a function of state and registered class), except:
  - FETCH IRWrite/PCWrite depend on mem_ready.
  - BRANCH PCWrite depends on Zero.
- Latency with mem_ready=1 in the first request cycle:
  - ALU op: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch/jump: 3 cycles
  - Each extra cycle of mem_ready=0 adds one cycle.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- mem_req stays high until the cycle mem_ready is seen; it drops the following cycle.
- Reset asserted mid-request: mem_req and MemWrite drop immediately (asynchronously); no retire is counted.

## Test plan
- Reset, then mem_ready=1 continuously; feed addu (Op=0, Funct=100001) → states 1,2,3,6,1. RegWrite high only in WB with GPRSel=00, ALUOp=0001; instret=1.
- lhu with 2 wait cycles on the data access → MEMRD lasts 3 cycles with mem_req=1, IorD=1, LAddr=100. Then WB: GPRSel=01, WDSel=01. Total 7 cycles.
- sb with mem_ready low 3 cycles → MemWrite=10 stable across all 4 MEMWR cycles, then FETCH; RegWrite never asserted.
- beq Zero=1 → PCWrite=1, NPCOp=01; bne Zero=1 → PCWrite=0. Both retire (instret +2).
- jal → JUMP: PCWrite=1, NPCOp=10, RegWrite=1, GPRSel=10, WDSel=10.
- Op=111111 → TRAP, illegal=1, no strobes, instret frozen. Assert rstn=0 mid-FETCH wait → mem_req=0 at once, state=IDLE, illegal=0.
